core_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32 core: steps each instruction through

---
 rtl/core_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core
// Strobes are decoded from the current state so an async reset drops them in the same cycle.
module core_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             trap_clr_i,
  output logic             imem_req_o,
  input  logic             imem_rvalid_i,
  output logic             ir_we_o,
  input  logic             dec_regfile_we_i,
  input  logic             dec_memread_i,
  input  logic             dec_memwrite_i,
  input  logic             dec_illegal_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ready_i,
  output logic             regfile_we_o,
  output logic             pc_we_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT_I = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0]  CAUSE_NONE    = 2'd0;
  localparam logic [1:0]  CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd2;
  localparam logic [15:0] TO_LIMIT      = 16'(TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [15:0]      to_cnt_inc;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  assign to_cnt_inc = to_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    cycle_d      = cycle_q;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    regfile_we_o = 1'b0;
    pc_we_o      = 1'b0;
    trap_o       = 1'b0;

    // Only cycles spent working on an instruction are counted.
    if (state_q != S_IDLE && state_q != S_TRAP) begin
      cycle_d = cycle_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        to_cnt_d   = '0;
        state_d    = S_WAIT_I;
      end
      S_WAIT_I: begin
        ir_we_o = imem_rvalid_i;
        if (imem_rvalid_i) begin
          state_d = S_DECODE;
        end else begin
          // Data arriving on the last permitted cycle takes priority over the trap.
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == TO_LIMIT) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (dec_illegal_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = (dec_memread_i || dec_memwrite_i) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_memwrite_i;
        if (dmem_ready_i) state_d = S_WB;
      end
      S_WB: begin
        regfile_we_o = dec_regfile_we_i && !dec_memwrite_i;
        pc_we_o      = 1'b1;
        instret_d    = instret_q + CNT_W'(1);
        state_d      = halt_i ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
        trap_o = 1'b1;
        if (trap_clr_i) begin
          state_d = S_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign trap_cause_o  = cause_q;
  assign state_o       = state_q;
  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl
// Expected per-cycle traces are generated from instruction descriptions, then replayed.
module tb_core_seq_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run_i = 1'b0, halt_i = 1'b0, trap_clr_i = 1'b0;
  logic          imem_rvalid_i = 1'b0, dmem_ready_i = 1'b0;
  logic          dec_regfile_we_i = 1'b0, dec_memread_i = 1'b0;
  logic          dec_memwrite_i = 1'b0, dec_illegal_i = 1'b0;
  logic          imem_req_o, ir_we_o, dmem_req_o, dmem_we_o;
  logic          regfile_we_o, pc_we_o, trap_o;
  logic [1:0]    trap_cause_o;
  logic [2:0]    state_o;
  logic [CW-1:0] cycle_cnt_o, instret_cnt_o;

  core_seq_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .halt_i(halt_i), .trap_clr_i(trap_clr_i),
    .imem_req_o(imem_req_o), .imem_rvalid_i(imem_rvalid_i), .ir_we_o(ir_we_o),
    .dec_regfile_we_i(dec_regfile_we_i), .dec_memread_i(dec_memread_i),
    .dec_memwrite_i(dec_memwrite_i), .dec_illegal_i(dec_illegal_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
    .regfile_we_o(regfile_we_o), .pc_we_o(pc_we_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    bit run, rv, rdy, halt, clr, mr, mw, rfw, ill;
    bit imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap, wb;
    logic [1:0] cause;
  } step_t;

  step_t q[$];
  int    n_cmp = 0, n_bad = 0, stepno = 0;
  int    cyc_m = 0, ret_m = 0;
  bit    idle_m = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic [2:0] st, input bit mr, input bit mw,
                               input bit rfw, input bit ill);
    step_t s;
    s.st = st; s.run = 0; s.rv = 0; s.rdy = 0; s.halt = 0; s.clr = 0;
    s.mr = mr; s.mw = mw; s.rfw = rfw; s.ill = ill;
    s.imem_req = 0; s.ir_we = 0; s.dmem_req = 0; s.dmem_we = 0;
    s.rf_we = 0; s.pc_we = 0; s.trap = (st == 3'd7); s.wb = 0; s.cause = 2'd0;
    return s;
  endfunction

  task automatic add_idle(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = mk(3'd0, 0, 0, 0, 0);
      s.halt = 1'($urandom_range(0, 1));
      q.push_back(s);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store. lat >= TO means the fetch never returns.
  task automatic add_instr(input int lat, input int kind, input int dwait,
                           input bit ill, input bit hlt, input int trap_cycles);
    step_t s;
    bit mr, mw, rfw, trapped;
    logic [1:0] cause;
    mr = (kind == 1); mw = (kind == 2); rfw = (kind != 2);
    trapped = 0; cause = 2'd0;
    if (idle_m) begin
      s = mk(3'd0, mr, mw, rfw, ill); s.run = 1; s.halt = 1'($urandom_range(0, 1));
      q.push_back(s);
    end
    s = mk(3'd1, mr, mw, rfw, ill); s.imem_req = 1; s.run = 1'($urandom_range(0, 1));
    q.push_back(s);
    for (int k = 0; k < TO; k++) begin
      s = mk(3'd2, mr, mw, rfw, ill);
      if (k == lat) begin
        s.rv = 1; s.ir_we = 1; q.push_back(s);
        break;
      end
      q.push_back(s);
      if (k + 1 == TO) begin trapped = 1; cause = 2'd2; end
    end
    if (!trapped) begin
      q.push_back(mk(3'd3, mr, mw, rfw, ill));
      if (ill) begin trapped = 1; cause = 2'd1; end
    end
    if (!trapped) begin
      q.push_back(mk(3'd4, mr, mw, rfw, ill));
      if (kind != 0) begin
        for (int d = 0; d <= dwait; d++) begin
          s = mk(3'd5, mr, mw, rfw, ill); s.dmem_req = 1; s.dmem_we = mw;
          s.rdy = (d == dwait);
          q.push_back(s);
        end
      end
      s = mk(3'd6, mr, mw, rfw, ill); s.rf_we = rfw; s.pc_we = 1; s.halt = hlt; s.wb = 1;
      q.push_back(s);
      idle_m = hlt;
    end else begin
      for (int t = 0; t <= trap_cycles; t++) begin
        s = mk(3'd7, mr, mw, rfw, ill); s.cause = cause; s.run = 1; s.clr = (t == trap_cycles);
        q.push_back(s);
      end
      idle_m = 1;
    end
  endtask

  task automatic play(input int n);
    step_t s;
    for (int i = 0; i < q.size() && i < n; i++) begin
      s = q[i];
      @(negedge clk);
      run_i = s.run; imem_rvalid_i = s.rv; dmem_ready_i = s.rdy; halt_i = s.halt;
      trap_clr_i = s.clr; dec_memread_i = s.mr; dec_memwrite_i = s.mw;
      dec_regfile_we_i = s.rfw; dec_illegal_i = s.ill;
      #1;
      stepno++;
      chk("state", 32'(state_o), 32'(s.st));
      chk("imem_req", 32'(imem_req_o), 32'(s.imem_req));
      chk("ir_we", 32'(ir_we_o), 32'(s.ir_we));
      chk("dmem_req", 32'(dmem_req_o), 32'(s.dmem_req));
      chk("dmem_we", 32'(dmem_we_o), 32'(s.dmem_we));
      chk("regfile_we", 32'(regfile_we_o), 32'(s.rf_we));
      chk("pc_we", 32'(pc_we_o), 32'(s.pc_we));
      chk("trap", 32'(trap_o), 32'(s.trap));
      chk("trap_cause", 32'(trap_cause_o), 32'(s.cause));
      chk("cycle_cnt", 32'(cycle_cnt_o), 32'(cyc_m));
      chk("instret_cnt", 32'(instret_cnt_o), 32'(ret_m));
      if (s.st != 3'd0 && s.st != 3'd7) cyc_m = (cyc_m + 1) % (1 << CW);
      if (s.wb) ret_m = (ret_m + 1) % (1 << CW);
    end
    q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_strobes"}, 32'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o,
                                regfile_we_o, pc_we_o, trap_o}), 32'd0);
    chk({tag, "_cause"}, 32'(trap_cause_o), 32'd0);
    chk({tag, "_cycle"}, 32'(cycle_cnt_o), 32'd0);
    chk({tag, "_instret"}, 32'(instret_cnt_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk_reset("rst_init");
    @(negedge clk) rst = 1'b1;

    // ALU op, load with 3 dmem wait cycles, store ending in halt, idle with frozen counters
    add_instr(0, 0, 0, 0, 0, 0);
    add_instr(0, 1, 3, 0, 0, 0);
    add_instr(1, 2, 0, 0, 1, 0);
    add_idle(3);
    play(1000);

    // fetch timeout, then rvalid on the last permitted cycle, then illegal decode
    add_instr(TO, 0, 0, 0, 0, 1);
    add_instr(TO - 1, 0, 0, 0, 1, 0);
    add_instr(0, 1, 0, 1, 0, 2);
    play(1000);

    for (int i = 0; i < 40; i++) begin
      add_instr($urandom_range(0, TO), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 2));
      if (idle_m && $urandom_range(0, 1) == 1) add_idle($urandom_range(1, 3));
      play(1000);
    end

    // async reset while a load sits in MEM
    add_instr(0, 1, 5, 0, 0, 0);
    play(q.size() - 4);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 stepno++;
    chk_reset("rst_mem");
    cyc_m = 0; ret_m = 0; idle_m = 1;
    @(negedge clk) rst = 1'b1;
    run_i = 1'b0;
    add_instr(0, 0, 0, 0, 1, 0);
    play(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
